// File: rtl/masked_skid_reg.sv
// Two-entry registered valid/ready skid buffer for a two-share Boolean-masked value.
// Optional feature: define MASKED_SKID_REFRESH_EN to re-mask both shares with rnd on input capture.
//
// state | meaning
// EMPTY | no pair held, out_valid=0, in_ready=1
// ONE   | main holds a pair, skid empty, out_valid=1, in_ready=1
// TWO   | main and skid both hold pairs, out_valid=1, in_ready=0
module masked_skid_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s0,
  input  logic [WIDTH-1:0] in_s1,
  input  logic [WIDTH-1:0] rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s0,
  output logic [WIDTH-1:0] out_s1,
  output logic [CNT_W-1:0] out_cnt
);

  // State bits are (main_full, skid_full).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_s0;
  logic [WIDTH-1:0] skid_s1;
  logic [WIDTH-1:0] cap_s0;
  logic [WIDTH-1:0] cap_s1;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Each share is refreshed on its own path; s0 and s1 never meet in logic.
`ifdef MASKED_SKID_REFRESH_EN
  assign cap_s0 = in_s0 ^ rnd;
  assign cap_s1 = in_s1 ^ rnd;
`else
  logic unused_rnd;
  assign unused_rnd = ^rnd;
  assign cap_s0 = in_s0;
  assign cap_s1 = in_s1;
`endif

  // Share registers are only loaded on capture/transfer, never cleared when emptying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_s0    <= '0;
      out_s1    <= '0;
      skid_s0   <= '0;
      skid_s1   <= '0;
      out_cnt   <= '0;
    end else begin
      if (out_fire) out_cnt <= out_cnt + CNT_W'(1);
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            out_s0    <= cap_s0;
            out_s1    <= cap_s1;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state    <= TWO;
            skid_s0  <= cap_s0;
            skid_s1  <= cap_s1;
            in_ready <= 1'b0;
          end else if (in_fire && out_fire) begin
            out_s0 <= cap_s0;
            out_s1 <= cap_s1;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state    <= ONE;
            out_s0   <= skid_s0;
            out_s1   <= skid_s1;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
